pmu_clk_seq: RTL and testbench
==============================

Name: pmu_clk_seq

Overview:
- Power/clock sequencer in the always-on 32 kHz PMU domain.
- Drives the clock-enable and soft-reset controls consumed by the clock/reset generation unit: efuse, shut-domain reset release, AFE, slot, data and timer clocks, and FIFO reset.
- Orders power-up (efuse load -> shut reset release -> AFE settle -> run) and power-down (slot/timer off -> data/AFE off -> shut reset assert) from a single top-start level.

Parameters:
AFE_SETTLE_CYC, 16, 32k cycles AFE clock runs before slot/data/timer enable (1..2^CNT_W-1)
EFUSE_TMO_CYC, 64, max 32k cycles waiting for efuse_done before timeout (1..2^CNT_W-1)
FIFO_RST_CYC, 2, 32k cycles pmu_fifo_rstn held low per flush (>=1)
CNT_W, 8, shared down-counter width

Ports:
clk_32k  input  1  always-on 32 kHz clock
rst_32k_alon_n  input  1  asynchronous active-low reset, always-on domain
top_start  input  1  run request level, already synchronised to clk_32k
efuse_done  input  1  efuse load complete level (32k domain)
fifo_flush_req  input  1  single-cycle FIFO reset request
efuse_clk_en  output  1  efuse clock enable
shut_rstn  output  1  shut-domain reset release (1 = released)
afe_clk_en  output  1  AFE clock enable
slot_clk_en  output  1  timeslot clock enable
data_clk_en  output  1  data_ctrl clock enable
timer_clk_en  output  1  timer clock enable
pmu_fifo_rstn  output  1  FIFO async reset source, active-low
seq_busy  output  1  1 in any state other than IDLE and RUN
seq_state  output  3  encoded FSM state
efuse_timeout  output  1  sticky efuse timeout flag

Behaviour:
- Clock, reset and output timing:
  - Clocking: single clock clk_32k; reset rst_32k_alon_n is asynchronous, active-low.
  - All outputs are registered.
  - Reset values: all outputs 0, seq_state = IDLE (0).
  - pmu_fifo_rstn rises to 1 on the first clk_32k edge after reset deassertion.
- Start detection: an internal top_start_d1 register (reset 0) provides the edge; start_pos = top_start & ~top_start_d1.
- States and encodings: IDLE=0, EFUSE=1, SHUT_REL=2, AFE_SETTLE=3, RUN=4, STOP_SLOT=5, STOP_AFE=6.
- IDLE: all enables 0, shut_rstn 0.
  - On start_pos: clear efuse_timeout.
  - Go to EFUSE, or to SHUT_REL if the efuse load is skipped (see Optional Feature).
- EFUSE:
  - efuse_clk_en=1; counter loaded with EFUSE_TMO_CYC-1 on entry.
  - Exit when efuse_done=1, or when the counter reaches 0 (the latter sets efuse_timeout=1).
  - Either exit goes to SHUT_REL, and efuse_clk_en drops on exit.
- SHUT_REL: shut_rstn=1; lasts exactly 1 cycle, then AFE_SETTLE.
- AFE_SETTLE:
  - afe_clk_en=1; counter loaded with AFE_SETTLE_CYC-1 on entry.
  - On counter 0, go to RUN.
- RUN:
  - slot_clk_en, data_clk_en and timer_clk_en all assert in the same cycle.
  - afe_clk_en and shut_rstn remain 1.
- Stop sequence:
  - Trigger: top_start=0 in SHUT_REL, AFE_SETTLE or RUN -> STOP_SLOT.
  - STOP_SLOT: slot_clk_en=0, timer_clk_en=0; 1 cycle.
  - STOP_AFE: data_clk_en=0, afe_clk_en=0; 1 cycle.
  - Then IDLE, where shut_rstn returns to 0.
- Abort: top_start=0 in EFUSE takes priority over efuse_done/timeout.
  - Go directly to IDLE; efuse_clk_en=0; shut_rstn never asserts; efuse_timeout unchanged.
- Restart during stop: top_start=1 during STOP_SLOT or STOP_AFE is ignored. The stop sequence completes, and a fresh start_pos is required.
- Counter: CNT_W bits, decrements by 1 per cycle, saturates at 0, no wrap.
- FIFO flush:
  - fifo_flush_req=1 loads a separate FIFO counter and drives pmu_fifo_rstn=0 for exactly FIFO_RST_CYC cycles.
  - A request while already low reloads the counter (extends the pulse).
  - Independent of the FSM.
  - The entry into STOP_AFE also triggers one flush pulse.
- Reset mid-sequence: asynchronously forces all outputs to reset values from any state.

Optional Feature:
- Macro: CRG_SEQ_EFUSE_RELOAD_EN.
- Defined: every start_pos goes IDLE -> EFUSE.
- Undefined:
  - An internal efuse_loaded flag (reset 0) is set on any EFUSE exit other than abort.
  - When the flag is 1, start_pos goes IDLE -> SHUT_REL directly, and efuse_clk_en stays 0.

Test Plan:
- Reset release, top_start=0 -> all enables 0, shut_rstn 0, pmu_fifo_rstn 1 after first edge, seq_state 0.
- Power-up: top_start 0->1, efuse_done at cycle 5 -> efuse_clk_en high 5 cycles, shut_rstn at next state, afe_clk_en 1, then slot/data/timer 1 exactly 16 cycles later, seq_state 4, efuse_timeout 0.
- Timeout: efuse_done held 0 -> efuse_clk_en high 64 cycles, efuse_timeout 1, sequence continues to RUN.
- Power-down from RUN: top_start 1->0 -> slot/timer 0 at cycle 1, data/afe 0 at cycle 2, shut_rstn 0 at cycle 3, pmu_fifo_rstn low 2 cycles starting with STOP_AFE.
- Abort: top_start drops in EFUSE cycle 3 -> IDLE next cycle, shut_rstn never 1. Second start without the macro and after a completed load -> EFUSE skipped.
- fifo_flush_req pulses at t and t+1 -> pmu_fifo_rstn low 3 cycles total. Async reset asserted in AFE_SETTLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/pmu_clk_seq_if.sv
// pmu_clk_seq_if: control/status bundle between the PMU sequencer and its user.
//   master: drives top_start, efuse_done, fifo_flush_req; observes the enables/status.
//   slave : the sequencer; receives the requests and drives efuse_clk_en, shut_rstn,
//           afe_clk_en, slot_clk_en, data_clk_en, timer_clk_en, pmu_fifo_rstn,
//           seq_busy, seq_state[2:0] and efuse_timeout.
interface pmu_clk_seq_if;
    logic       top_start;
    logic       efuse_done;
    logic       fifo_flush_req;
    logic       efuse_clk_en;
    logic       shut_rstn;
    logic       afe_clk_en;
    logic       slot_clk_en;
    logic       data_clk_en;
    logic       timer_clk_en;
    logic       pmu_fifo_rstn;
    logic       seq_busy;
    logic [2:0] seq_state;
    logic       efuse_timeout;
    modport master (
        output top_start, efuse_done, fifo_flush_req,
        input  efuse_clk_en, shut_rstn, afe_clk_en, slot_clk_en, data_clk_en,
               timer_clk_en, pmu_fifo_rstn, seq_busy, seq_state, efuse_timeout
    );
    modport slave (
        input  top_start, efuse_done, fifo_flush_req,
        output efuse_clk_en, shut_rstn, afe_clk_en, slot_clk_en, data_clk_en,
               timer_clk_en, pmu_fifo_rstn, seq_busy, seq_state, efuse_timeout
    );
endinterface

// File: rtl/pmu_clk_seq.sv
// pmu_clk_seq: always-on 32 kHz power/clock sequencer (efuse -> shut reset -> AFE -> run, and back).
//   clk_32k        : always-on 32 kHz clock
//   rst_32k_alon_n : asynchronous active-low reset
//   bus (slave)    : top_start/efuse_done/fifo_flush_req in; clock enables, shut_rstn,
//                    pmu_fifo_rstn, seq_busy, seq_state, efuse_timeout out (all registered)
//   Macro CRG_SEQ_EFUSE_RELOAD_EN: when defined every start reloads the efuse; otherwise
//   the efuse is loaded once and later starts go straight to shut reset release.
module pmu_clk_seq #(
    parameter int AFE_SETTLE_CYC = 16,
    parameter int EFUSE_TMO_CYC  = 64,
    parameter int FIFO_RST_CYC   = 2,
    parameter int CNT_W          = 8
) (
    input logic         clk_32k,
    input logic         rst_32k_alon_n,
    pmu_clk_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EFUSE      = 3'd1,
        SHUT_REL   = 3'd2,
        AFE_SETTLE = 3'd3,
        RUN        = 3'd4,
        STOP_SLOT  = 3'd5,
        STOP_AFE   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] EFUSE_LOAD = CNT_W'(EFUSE_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] AFE_LOAD   = CNT_W'(AFE_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] FIFO_LOAD  = CNT_W'(FIFO_RST_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, fcnt;
    logic             top_start_d1, start_pos, skip_efuse, efuse_exit, timeout_hit, flush;

    assign start_pos   = bus.top_start & ~top_start_d1;
    assign efuse_exit  = state == EFUSE && bus.top_start && (bus.efuse_done || cnt == '0);
    assign timeout_hit = efuse_exit & ~bus.efuse_done;
    assign flush       = bus.fifo_flush_req | (state_nxt == STOP_AFE && state != STOP_AFE);
    assign bus.seq_state = state;

`ifdef CRG_SEQ_EFUSE_RELOAD_EN
    assign skip_efuse = 1'b0;
`else
    logic efuse_loaded;
    always_ff @(posedge clk_32k or negedge rst_32k_alon_n)
        if (!rst_32k_alon_n) efuse_loaded <= 1'b0;
        else if (efuse_exit) efuse_loaded <= 1'b1;
    assign skip_efuse = efuse_loaded;
`endif

    always_ff @(posedge clk_32k or negedge rst_32k_alon_n)
        if (!rst_32k_alon_n) state <= IDLE;
        else state <= state_nxt;

    // Abort (top_start low) outranks every forward transition; STOP_* states ignore top_start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = start_pos ? (skip_efuse ? SHUT_REL : EFUSE) : IDLE;
            EFUSE:      state_nxt = !bus.top_start ? IDLE : efuse_exit ? SHUT_REL : EFUSE;
            SHUT_REL:   state_nxt = bus.top_start ? AFE_SETTLE : STOP_SLOT;
            AFE_SETTLE: state_nxt = !bus.top_start ? STOP_SLOT : cnt == '0 ? RUN : AFE_SETTLE;
            RUN:        state_nxt = bus.top_start ? RUN : STOP_SLOT;
            STOP_SLOT:  state_nxt = STOP_AFE;
            STOP_AFE:   state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Shared timer: loaded on entry to a timed state, saturating down-count otherwise.
    always_ff @(posedge clk_32k or negedge rst_32k_alon_n)
        if (!rst_32k_alon_n) cnt <= '0;
        else if (state_nxt == EFUSE && state != EFUSE) cnt <= EFUSE_LOAD;
        else if (state_nxt == AFE_SETTLE && state != AFE_SETTLE) cnt <= AFE_LOAD;
        else if (cnt != '0) cnt <= cnt - 1'b1;

    // Outputs are registered from the next state so they line up with seq_state.
    // afe/data hold through STOP_SLOT only if they were already on, so an early stop
    // from SHUT_REL or AFE_SETTLE never switches on a clock that was off.
    always_ff @(posedge clk_32k or negedge rst_32k_alon_n)
        if (!rst_32k_alon_n) begin
            top_start_d1      <= 1'b0;
            bus.efuse_clk_en  <= 1'b0;
            bus.shut_rstn     <= 1'b0;
            bus.afe_clk_en    <= 1'b0;
            bus.slot_clk_en   <= 1'b0;
            bus.data_clk_en   <= 1'b0;
            bus.timer_clk_en  <= 1'b0;
            bus.seq_busy      <= 1'b0;
            bus.efuse_timeout <= 1'b0;
        end else begin
            top_start_d1      <= bus.top_start;
            bus.efuse_clk_en  <= state_nxt == EFUSE;
            bus.shut_rstn     <= state_nxt != IDLE && state_nxt != EFUSE;
            bus.afe_clk_en    <= state_nxt == AFE_SETTLE || state_nxt == RUN ||
                                 (state_nxt == STOP_SLOT && bus.afe_clk_en);
            bus.data_clk_en   <= state_nxt == RUN || (state_nxt == STOP_SLOT && bus.data_clk_en);
            bus.slot_clk_en   <= state_nxt == RUN;
            bus.timer_clk_en  <= state_nxt == RUN;
            bus.seq_busy      <= state_nxt != IDLE && state_nxt != RUN;
            bus.efuse_timeout <= (state == IDLE && start_pos) ? 1'b0 :
                                 timeout_hit ? 1'b1 : bus.efuse_timeout;
        end

    // FIFO reset pulse: a request (or a new one while low) reloads the pulse length.
    always_ff @(posedge clk_32k or negedge rst_32k_alon_n)
        if (!rst_32k_alon_n) begin
            fcnt              <= '0;
            bus.pmu_fifo_rstn <= 1'b0;
        end else if (flush) begin
            fcnt              <= FIFO_LOAD;
            bus.pmu_fifo_rstn <= 1'b0;
        end else begin
            fcnt              <= fcnt != '0 ? fcnt - 1'b1 : fcnt;
            bus.pmu_fifo_rstn <= fcnt == '0;
        end
endmodule

// File: tb/tb_pmu_clk_seq.sv
// tb_pmu_clk_seq: directed bench for pmu_clk_seq (default build, efuse loaded once).
module tb_pmu_clk_seq;
    logic clk_32k = 1'b0;
    logic rst_32k_alon_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    pmu_clk_seq_if bus();

    pmu_clk_seq dut (
        .clk_32k        (clk_32k),
        .rst_32k_alon_n (rst_32k_alon_n),
        .bus            (bus)
    );

    always #5 clk_32k = ~clk_32k;

    // {efuse, shut_rstn, afe, slot, data, timer, fifo_rstn, busy}
    logic [7:0] outs;
    assign outs = {bus.efuse_clk_en, bus.shut_rstn, bus.afe_clk_en, bus.slot_clk_en,
                   bus.data_clk_en, bus.timer_clk_en, bus.pmu_fifo_rstn, bus.seq_busy};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_32k);
        #1;
    endtask

    task automatic st(input string tag, input logic [2:0] s, input logic [7:0] o);
        chk({tag, "_state"}, 32'(bus.seq_state), 32'(s));
        chk({tag, "_outs"}, 32'(outs), 32'(o));
    endtask

    initial begin
        bus.top_start = 1'b0;
        bus.efuse_done = 1'b0;
        bus.fifo_flush_req = 1'b0;
        tick(2);
        st("in_reset", 3'd0, 8'b0000_0000);
        chk("in_reset_tmo", 32'(bus.efuse_timeout), 0);
        rst_32k_alon_n = 1'b1;
        tick(1);
        st("rst_rel", 3'd0, 8'b0000_0010);
        // abort in EFUSE cycle 3
        bus.top_start = 1'b1;
        tick(1);
        st("abort_efuse1", 3'd1, 8'b1000_0011);
        tick(2);
        st("abort_efuse3", 3'd1, 8'b1000_0011);
        bus.top_start = 1'b0;
        tick(1);
        st("abort_idle", 3'd0, 8'b0000_0010);
        chk("abort_tmo", 32'(bus.efuse_timeout), 0);
        // power-up with efuse_done seen in EFUSE cycle 5
        bus.top_start = 1'b1;
        tick(1);
        st("pu_efuse1", 3'd1, 8'b1000_0011);
        tick(4);
        st("pu_efuse5", 3'd1, 8'b1000_0011);
        bus.efuse_done = 1'b1;
        tick(1);
        st("pu_shut", 3'd2, 8'b0100_0011);
        tick(1);
        st("pu_afe1", 3'd3, 8'b0110_0011);
        tick(15);
        st("pu_afe16", 3'd3, 8'b0110_0011);
        tick(1);
        st("pu_run", 3'd4, 8'b0111_1110);
        chk("pu_tmo", 32'(bus.efuse_timeout), 0);
        bus.efuse_done = 1'b0;
        tick(3);
        st("pu_run_hold", 3'd4, 8'b0111_1110);
        // power-down from RUN
        bus.top_start = 1'b0;
        tick(1);
        st("pd_slot", 3'd5, 8'b0110_1011);
        tick(1);
        st("pd_afe", 3'd6, 8'b0100_0001);
        tick(1);
        st("pd_idle", 3'd0, 8'b0000_0000);
        tick(1);
        st("pd_fifo_up", 3'd0, 8'b0000_0010);
        // second start skips EFUSE; async reset in AFE_SETTLE
        bus.top_start = 1'b1;
        tick(1);
        st("skip_shut", 3'd2, 8'b0100_0011);
        tick(1);
        st("skip_afe", 3'd3, 8'b0110_0011);
        tick(3);
        rst_32k_alon_n = 1'b0;
        #1;
        st("async_rst", 3'd0, 8'b0000_0000);
        bus.top_start = 1'b0;
        tick(1);
        rst_32k_alon_n = 1'b1;
        tick(1);
        st("async_rel", 3'd0, 8'b0000_0010);
        // efuse timeout (load flag cleared by reset)
        bus.top_start = 1'b1;
        tick(1);
        st("tmo_efuse1", 3'd1, 8'b1000_0011);
        tick(63);
        st("tmo_efuse64", 3'd1, 8'b1000_0011);
        chk("tmo_not_yet", 32'(bus.efuse_timeout), 0);
        tick(1);
        st("tmo_shut", 3'd2, 8'b0100_0011);
        chk("tmo_set", 32'(bus.efuse_timeout), 1);
        tick(17);
        st("tmo_run", 3'd4, 8'b0111_1110);
        bus.top_start = 1'b0;
        tick(4);
        st("tmo_idle", 3'd0, 8'b0000_0010);
        chk("tmo_sticky", 32'(bus.efuse_timeout), 1);
        // next start clears timeout; stop from SHUT_REL; restart during stop ignored
        bus.top_start = 1'b1;
        tick(1);
        st("re_shut", 3'd2, 8'b0100_0011);
        chk("re_tmo_clr", 32'(bus.efuse_timeout), 0);
        bus.top_start = 1'b0;
        tick(1);
        st("re_slot", 3'd5, 8'b0100_0011);
        bus.top_start = 1'b1;
        tick(1);
        st("re_afe", 3'd6, 8'b0100_0001);
        tick(1);
        st("re_idle", 3'd0, 8'b0000_0000);
        tick(2);
        st("re_stay_idle", 3'd0, 8'b0000_0010);
        bus.top_start = 1'b0;
        // FIFO flush: single request, then back-to-back requests
        bus.fifo_flush_req = 1'b1;
        tick(1);
        bus.fifo_flush_req = 1'b0;
        chk("fl1_c1", 32'(bus.pmu_fifo_rstn), 0);
        tick(1);
        chk("fl1_c2", 32'(bus.pmu_fifo_rstn), 0);
        tick(1);
        chk("fl1_end", 32'(bus.pmu_fifo_rstn), 1);
        bus.fifo_flush_req = 1'b1;
        tick(1);
        chk("fl2_c1", 32'(bus.pmu_fifo_rstn), 0);
        tick(1);
        bus.fifo_flush_req = 1'b0;
        chk("fl2_c2", 32'(bus.pmu_fifo_rstn), 0);
        tick(1);
        chk("fl2_c3", 32'(bus.pmu_fifo_rstn), 0);
        tick(1);
        chk("fl2_end", 32'(bus.pmu_fifo_rstn), 1);
        chk("fl_fsm_idle", 32'(bus.seq_state), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
